// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_pkg;

    typedef enum logic [1:0] {
        CD_IDLE = 2'd0,
        CD_RUN  = 2'd1,
        CD_DONE = 2'd2
    } cd_state_t;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Tick prescaler: emits a one-cycle tick on every DIV-th enable; only built when PRESCALE_EN is defined.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_top;

    assign at_top = (cnt_q == CW'(DIV - 1));
    // Tick is combinational so the counter consumes it on the same enable that completes the period.
    assign tick   = en && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_top ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/done handshake and optional auto-reload.
// Optional feature macro: PRESCALE_EN (divides count_enable by PRESCALE_DIV before counting).
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int PRESCALE_DIV = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    sync_reset,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    auto_reload,
    input  logic                    count_enable,
    input  logic                    done_ack,
    output logic [NUM_CNT_BITS-1:0] value,
    output logic                    zero_flag,
    output logic                    busy,
    output logic                    done
);

    if (PRESCALE_DIV < 2) begin : g_bad_div
        $error("PRESCALE_DIV must be >= 2");
    end

    cd_state_t               state_q, state_d;
    logic [NUM_CNT_BITS-1:0] value_q, value_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    zero_q, zero_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tick;

`ifdef PRESCALE_EN
    tick_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (sync_reset || load),
        .en    (count_enable && (state_q == CD_RUN)),
        .tick  (tick)
    );
`else
    assign tick = count_enable;
`endif

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        reload_d = reload_q;
        zero_d   = zero_q;
        if (sync_reset) begin
            state_d  = CD_IDLE;
            value_d  = '0;
            reload_d = '0;
            zero_d   = 1'b0;
        end else if (load) begin
            state_d  = CD_RUN;
            value_d  = load_val;
            reload_d = load_val;
            zero_d   = (load_val == '0);
        end else if (state_q == CD_RUN && tick) begin
            if (value_q != '0) begin
                value_d = value_q - 1'b1;
                zero_d  = (value_q == NUM_CNT_BITS'(1));
            end else if (auto_reload) begin
                value_d = reload_q;
                zero_d  = (reload_q == '0);
            end else begin
                state_d = CD_DONE;
                zero_d  = 1'b0;
            end
        end else if (state_q == CD_DONE && done_ack) begin
            state_d = CD_IDLE;
        end
        busy_d = (state_d == CD_RUN);
        done_d = (state_d == CD_DONE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= CD_IDLE;
            value_q  <= '0;
            reload_q <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            reload_q <= reload_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign value     = value_q;
    assign zero_flag = zero_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle expectations queued on drive, checked after the edge.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         n_rst, sync_reset, load, auto_reload, count_enable, done_ack;
    logic [W-1:0] load_val;
    logic [W-1:0] value;
    logic         zero_flag, busy, done;

    typedef struct {
        string        tag;
        logic [W-1:0] value;
        logic         zf;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    countdown_timer #(
        .NUM_CNT_BITS (W),
        .PRESCALE_DIV (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sync_reset   (sync_reset),
        .load         (load),
        .load_val     (load_val),
        .auto_reload  (auto_reload),
        .count_enable (count_enable),
        .done_ack     (done_ack),
        .value        (value),
        .zero_flag    (zero_flag),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue expected outputs, check after the edge.
    task automatic cyc(input string tag, input logic rst_n, input logic sr, input logic ld,
                       input logic [W-1:0] lv, input logic ar, input logic ce, input logic ack,
                       input logic [W-1:0] ev, input logic ezf, input logic eb, input logic ed);
        exp_t e;
        n_rst        = rst_n;
        sync_reset   = sr;
        load         = ld;
        load_val     = lv;
        auto_reload  = ar;
        count_enable = ce;
        done_ack     = ack;
        e.tag = tag; e.value = ev; e.zf = ezf; e.busy = eb; e.done = ed;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_value"}, 32'(value), 32'(e.value));
            chk({e.tag, "_zf"},    32'(zero_flag), 32'(e.zf));
            chk({e.tag, "_busy"},  32'(busy), 32'(e.busy));
            chk({e.tag, "_done"},  32'(done), 32'(e.done));
        end
    endtask

    initial begin
        //        tag          rst sr ld lv ar ce ack   val zf b d
        cyc("reset0",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        cyc("reset1",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        cyc("idle",          1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
`ifndef PRESCALE_EN
        // one-shot count from 3
        cyc("os_load",       1, 0, 1, 3, 0, 0, 0,   3, 0, 1, 0);
        cyc("os_hold",       1, 0, 0, 9, 0, 0, 0,   3, 0, 1, 0);
        cyc("os_2",          1, 0, 0, 9, 0, 1, 0,   2, 0, 1, 0);
        cyc("os_1",          1, 0, 0, 9, 0, 1, 1,   1, 0, 1, 0);
        cyc("os_0",          1, 0, 0, 9, 0, 1, 0,   0, 1, 1, 0);
        cyc("os_done",       1, 0, 0, 9, 0, 1, 0,   0, 0, 0, 1);
        cyc("os_done_hold",  1, 0, 0, 9, 1, 1, 0,   0, 0, 0, 1);
        cyc("os_ack",        1, 0, 0, 9, 0, 0, 1,   0, 0, 0, 0);
        // auto-reload from 2
        cyc("ar_load",       1, 0, 1, 2, 1, 1, 0,   2, 0, 1, 0);
        cyc("ar_1",          1, 0, 0, 0, 1, 1, 0,   1, 0, 1, 0);
        cyc("ar_0",          1, 0, 0, 0, 1, 1, 0,   0, 1, 1, 0);
        cyc("ar_rl",         1, 0, 0, 0, 1, 1, 0,   2, 0, 1, 0);
        cyc("ar_1b",         1, 0, 0, 0, 1, 1, 0,   1, 0, 1, 0);
        cyc("ar_0b",         1, 0, 0, 0, 1, 1, 0,   0, 1, 1, 0);
        cyc("ar_rl2",        1, 0, 0, 0, 1, 1, 0,   2, 0, 1, 0);
        // async-to-count reset mid-run
        cyc("rst_load",      1, 0, 1, 5, 0, 0, 0,   5, 0, 1, 0);
        cyc("rst_mid0",      0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        cyc("rst_mid1",      0, 0, 1, 6, 0, 1, 0,   0, 0, 0, 0);
        cyc("rst_after",     1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        // priority: load over tick, sync_reset over load
        cyc("pr_load1",      1, 0, 1, 1, 0, 0, 0,   1, 0, 1, 0);
        cyc("pr_load_tick",  1, 0, 1, 7, 0, 1, 0,   7, 0, 1, 0);
        cyc("pr_ack_run",    1, 0, 0, 7, 0, 0, 1,   7, 0, 1, 0);
        cyc("pr_sr_load",    1, 1, 1, 3, 0, 1, 0,   0, 0, 0, 0);
        // zero load value
        cyc("z_load",        1, 0, 1, 0, 0, 0, 0,   0, 1, 1, 0);
        cyc("z_hold",        1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        cyc("z_done",        1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
        cyc("z_reload_done", 1, 0, 1, 15, 0, 1, 0, 15, 0, 1, 0);
        cyc("z_14",          1, 0, 0, 0, 0, 1, 0,  14, 0, 1, 0);
        cyc("z_ar_load",     1, 0, 1, 0, 1, 0, 0,   0, 1, 1, 0);
        cyc("z_ar_tick",     1, 0, 0, 0, 1, 1, 0,   0, 1, 1, 0);
        cyc("z_sr",          1, 1, 0, 0, 1, 1, 0,   0, 0, 0, 0);
`else
        // prescaled: load 1, tick every 4 enables, gaps hold progress
        cyc("ps_load",       1, 0, 1, 1, 0, 0, 0,   1, 0, 1, 0);
        cyc("ps_e1",         1, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
        cyc("ps_e2",         1, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
        cyc("ps_gap",        1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0);
        cyc("ps_e3",         1, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
        cyc("ps_e4",         1, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0);
        cyc("ps_e5",         1, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0);
        cyc("ps_gap2",       1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        cyc("ps_e6",         1, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0);
        cyc("ps_e7",         1, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0);
        cyc("ps_e8",         1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
        cyc("ps_ack",        1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
